// File: rtl/cdc_stim_gen_if.sv
// Word announcement bundle between the stimulus source and the synchronizer paths it drives.
interface cdc_stim_gen_if #(parameter int N = 8);
  logic [N-1:0] data_out;
  logic         stb;
  logic         tog;
  logic         req;
  logic         busy;
  logic [7:0]   word_cnt;
  logic         ack_async;

  modport master (output data_out, stb, tog, req, busy, word_cnt, input ack_async);
  modport slave  (input data_out, stb, tog, req, busy, word_cnt, output ack_async);
endinterface

// File: rtl/cdc_stim_gen.sv
// Source-domain stimulus generator: emits pattern words as strobe, toggle and 4-phase req,
// paced by the synchronized acknowledge from the destination domain.
module cdc_stim_gen #(
  parameter int N     = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  cdc_stim_gen_if.master   bus
);
  typedef enum logic [1:0] {IDLE, REQ, ACKLO, GAP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [N-1:0]     pat_q, pat_d;
  logic [N-1:0]     data_q, data_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             stb_q, stb_d;
  logic             tog_q, tog_d;
  logic             req_q, req_d;
  logic             ack_s, emit;
  logic [1:0]       pmode;
  logic [N-1:0]     src;

  function automatic logic [N-1:0] seed_of(input logic [1:0] m);
    logic [N-1:0] s;
    s = '0;
    if (m == 2'b11) begin
      for (int i = 0; i < N; i++) s[i] = ~i[0];
    end else begin
      s[0] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [N-1:0] step(input logic [1:0] m, input logic [N-1:0] p);
    case (m)
      2'b00:   return p + N'(1);
      2'b01:   return {p[N-2:0], p[N-1] ^ p[N-3] ^ p[N-4] ^ p[N-5]};
      2'b10:   return {p[N-2:0], p[N-1]};
      default: return ~p;
    endcase
  endfunction

  assign ack_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    data_d  = data_q;
    gcnt_d  = gcnt_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    tog_d   = tog_q;
    req_d   = req_q;
    stb_d   = 1'b0;
    emit    = 1'b0;
    pmode   = mode_q;
    src     = pat_q;
    if (ena) begin
      sync_d = {sync_q[0], bus.ack_async};
      case (state_q)
        IDLE: if (start) begin
          // A start from IDLE re-seeds and emits in the same edge.
          emit   = 1'b1;
          pmode  = mode;
          src    = seed_of(mode);
          mode_d = mode;
          cnt_d  = '0;
        end
        REQ: if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACKLO;
        end
        ACKLO: if (!ack_s) begin
          gcnt_d  = gap;
          state_d = GAP;
        end
        GAP: begin
          if (gcnt_q != '0)  gcnt_d  = gcnt_q - GAP_W'(1);
          else if (start)    emit    = 1'b1;
          else               state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (emit) begin
        data_d  = src;
        pat_d   = step(pmode, src);
        stb_d   = 1'b1;
        tog_d   = ~tog_q;
        req_d   = 1'b1;
        cnt_d   = cnt_d + 8'd1;
        state_d = REQ;
      end
    end
  end

  // stb_q clears even when ena=0 so a stalled strobe never re-appears as a second pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      pat_q   <= N'(1);
      data_q  <= '0;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
      stb_q   <= 1'b0;
      tog_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      stb_q   <= stb_d;
      tog_q   <= tog_d;
      req_q   <= req_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.stb      = stb_q & ena;
  assign bus.tog      = tog_q;
  assign bus.req      = req_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.word_cnt = cnt_q;
endmodule
